multi_cycle_ctrl: RTL and testbench

- Control-unit FSM for the multi-cycle CPU; directly upstream of the register file.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Produces RegWre, RegDst and write-data select for the register file, plus PC, IR, ALU and data-memory controls.
- Decodes opcode/funct from the instruction register and the ALU zero flag.

---
 rtl/multi_cycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: sequences IF/ID/EXE/MEM/WB and decodes
// opcode/funct/zero into PC, IR, register-file, ALU and data-memory controls.
module multi_cycle_ctrl #(
  parameter logic [5:0] OP_HALT  = 6'b111111,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic [1:0] WrDataSrc,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc,
  output logic [2:0] state
);

  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_AL  = 3'b111;
  localparam logic [2:0] S_WB_LD  = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // The register file hardwires RegDst=00 to the link register.
  localparam logic [1:0] DST_LINK = (LINK_REG == 5'd31) ? 2'b00 : 2'b00;

  logic [2:0] state_q, state_d;
  logic is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_j, is_jal, is_halt;

  always_comb begin
    is_r    = (opcode == OP_RTYPE);
    is_addi = (opcode == OP_ADDI);
    is_ori  = (opcode == OP_ORI);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_beq  = (opcode == OP_BEQ);
    is_j    = (opcode == OP_J);
    is_jal  = (opcode == OP_JAL);
    is_halt = (opcode == OP_HALT);
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_r || is_addi || is_ori) state_d = S_EXE_AL;
        else if (is_beq)               state_d = S_EXE_BR;
        else if (is_lw || is_sw)       state_d = S_EXE_LS;
        else if (is_halt)              state_d = S_ID;
        else                           state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
      S_WB_AL:  state_d = S_IF;
      S_WB_LD:  state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  // Datapath selects depend only on the instruction class.
  always_comb begin
    ALUSrcB = is_addi || is_ori || is_lw || is_sw;
    ExtSel  = !is_ori;
    ALUOp   = ALU_ADD;
    if (is_ori) begin
      ALUOp = ALU_OR;
    end else if (is_beq) begin
      ALUOp = ALU_SUB;
    end else if (is_r) begin
      case (funct)
        6'b100010: ALUOp = ALU_SUB;
        6'b100100: ALUOp = ALU_AND;
        6'b100101: ALUOp = ALU_OR;
        6'b101010: ALUOp = ALU_SLT;
        default:   ALUOp = ALU_ADD;
      endcase
    end
  end

  logic pc_wre, ir_wre, reg_wre, m_rd, m_wr;

  always_comb begin
    pc_wre    = 1'b0;
    ir_wre    = 1'b0;
    reg_wre   = 1'b0;
    m_rd      = 1'b0;
    m_wr      = 1'b0;
    RegDst    = 2'b00;
    WrDataSrc = 2'b00;
    PCSrc     = 2'b00;
    case (state_q)
      S_IF: ir_wre = 1'b1;
      S_ID: begin
        if (is_j || is_jal) PCSrc = 2'b10;
        if (is_jal) begin
          reg_wre   = 1'b1;
          RegDst    = DST_LINK;
          WrDataSrc = 2'b10;
        end
        // Anything not dispatched to an EXE state (and not halt) ends here.
        pc_wre = !(is_r || is_addi || is_ori || is_beq || is_lw || is_sw || is_halt);
      end
      S_EXE_BR: begin
        pc_wre = 1'b1;
        PCSrc  = zero ? 2'b01 : 2'b00;
      end
      S_MEM: begin
        m_rd   = is_lw;
        m_wr   = is_sw;
        pc_wre = is_sw;
      end
      S_WB_AL: begin
        pc_wre  = 1'b1;
        reg_wre = 1'b1;
        RegDst  = is_r ? 2'b10 : 2'b01;
      end
      S_WB_LD: begin
        pc_wre    = 1'b1;
        reg_wre   = 1'b1;
        RegDst    = 2'b01;
        WrDataSrc = 2'b01;
      end
      default: ;
    endcase
  end

  // Reset blocks every architectural write, so an aborted instruction leaves no trace.
  always_comb begin
    PCWre  = pc_wre  && !RST;
    IRWre  = ir_wre  && !RST;
    RegWre = reg_wre && !RST;
    mRD    = m_rd    && !RST;
    mWR    = m_wr    && !RST;
    state  = state_q;
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed-vector bench for multi_cycle_ctrl with hand-computed expectations.
module tb_multi_cycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       PCWre, IRWre, RegWre, ALUSrcB, ExtSel, mRD, mWR;
  logic [1:0] RegDst, WrDataSrc, PCSrc;
  logic [2:0] ALUOp, state;

  int checks = 0;
  int errors = 0;

  multi_cycle_ctrl dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrDataSrc(WrDataSrc), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
    .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
    step();
    step();
    chk("rst_state", 8'(state), 8'h0);
    chk("rst_pcwre", 8'(PCWre), 8'h0);
    chk("rst_irwre", 8'(IRWre), 8'h0);
    chk("rst_regwre", 8'(RegWre), 8'h0);
    chk("rst_mwr", 8'(mWR), 8'h0);
    RST = 1'b0; #1;
    chk("post_rst_irwre", 8'(IRWre), 8'h1);

    // R-type add
    step(); chk("add_id", 8'(state), 8'h1);
    chk("add_id_pcwre", 8'(PCWre), 8'h0);
    step(); chk("add_exe", 8'(state), 8'h6);
    step(); chk("add_wb", 8'(state), 8'h7);
    chk("add_wb_regwre", 8'(RegWre), 8'h1);
    chk("add_wb_regdst", 8'(RegDst), 8'h2);
    chk("add_wb_wrsrc", 8'(WrDataSrc), 8'h0);
    chk("add_wb_aluop", 8'(ALUOp), 8'h0);
    chk("add_wb_pcwre", 8'(PCWre), 8'h1);
    step(); chk("add_done", 8'(state), 8'h0);

    // R-type sub, slt and an unknown funct
    funct = 6'b100010; #1; chk("sub_aluop", 8'(ALUOp), 8'h1);
    funct = 6'b101010; #1; chk("slt_aluop", 8'(ALUOp), 8'h4);
    funct = 6'b100100; #1; chk("and_aluop", 8'(ALUOp), 8'h2);
    funct = 6'b111111; #1; chk("unk_aluop", 8'(ALUOp), 8'h0);
    step(); step(); step();
    chk("unk_wb_state", 8'(state), 8'h7);
    chk("unk_wb_regwre", 8'(RegWre), 8'h1);
    step();

    // ori: zero-extend, OR, rt destination
    opcode = 6'b001101; #1;
    chk("ori_aluop", 8'(ALUOp), 8'h3);
    chk("ori_extsel", 8'(ExtSel), 8'h0);
    chk("ori_alusrcb", 8'(ALUSrcB), 8'h1);
    step(); step(); step();
    chk("ori_wb_regdst", 8'(RegDst), 8'h1);
    step();

    // lw
    opcode = 6'b100011; #1;
    chk("lw_if_mrd", 8'(mRD), 8'h0);
    chk("lw_extsel", 8'(ExtSel), 8'h1);
    step(); chk("lw_id", 8'(state), 8'h1);
    step(); chk("lw_exe", 8'(state), 8'h2);
    chk("lw_exe_mrd", 8'(mRD), 8'h0);
    step(); chk("lw_mem", 8'(state), 8'h3);
    chk("lw_mem_mrd", 8'(mRD), 8'h1);
    chk("lw_mem_pcwre", 8'(PCWre), 8'h0);
    step(); chk("lw_wb", 8'(state), 8'h4);
    chk("lw_wb_mrd", 8'(mRD), 8'h0);
    chk("lw_wb_regwre", 8'(RegWre), 8'h1);
    chk("lw_wb_regdst", 8'(RegDst), 8'h1);
    chk("lw_wb_wrsrc", 8'(WrDataSrc), 8'h1);
    chk("lw_wb_pcwre", 8'(PCWre), 8'h1);
    step(); chk("lw_done", 8'(state), 8'h0);

    // sw
    opcode = 6'b101011;
    step(); chk("sw_id", 8'(state), 8'h1);
    chk("sw_id_regwre", 8'(RegWre), 8'h0);
    step(); chk("sw_exe", 8'(state), 8'h2);
    chk("sw_exe_regwre", 8'(RegWre), 8'h0);
    step(); chk("sw_mem", 8'(state), 8'h3);
    chk("sw_mem_mwr", 8'(mWR), 8'h1);
    chk("sw_mem_pcwre", 8'(PCWre), 8'h1);
    chk("sw_mem_regwre", 8'(RegWre), 8'h0);
    chk("sw_mem_mrd", 8'(mRD), 8'h0);
    step(); chk("sw_done", 8'(state), 8'h0);

    // beq taken
    opcode = 6'b000100; zero = 1'b1;
    step(); step(); chk("beqt_exe", 8'(state), 8'h5);
    chk("beqt_pcsrc", 8'(PCSrc), 8'h1);
    chk("beqt_pcwre", 8'(PCWre), 8'h1);
    chk("beqt_aluop", 8'(ALUOp), 8'h1);
    step(); chk("beqt_done", 8'(state), 8'h0);

    // beq not taken
    zero = 1'b0;
    step(); step(); chk("beqn_exe", 8'(state), 8'h5);
    chk("beqn_pcsrc", 8'(PCSrc), 8'h0);
    chk("beqn_pcwre", 8'(PCWre), 8'h1);
    step(); chk("beqn_done", 8'(state), 8'h0);

    // jal
    opcode = 6'b000011;
    step(); chk("jal_id", 8'(state), 8'h1);
    chk("jal_regwre", 8'(RegWre), 8'h1);
    chk("jal_regdst", 8'(RegDst), 8'h0);
    chk("jal_wrsrc", 8'(WrDataSrc), 8'h2);
    chk("jal_pcsrc", 8'(PCSrc), 8'h2);
    chk("jal_pcwre", 8'(PCWre), 8'h1);
    step(); chk("jal_done", 8'(state), 8'h0);

    // j and an undefined opcode (NOP)
    opcode = 6'b000010;
    step(); chk("j_pcsrc", 8'(PCSrc), 8'h2);
    chk("j_regwre", 8'(RegWre), 8'h0);
    step(); chk("j_done", 8'(state), 8'h0);
    opcode = 6'b111000;
    step(); chk("nop_pcwre", 8'(PCWre), 8'h1);
    chk("nop_pcsrc", 8'(PCSrc), 8'h0);
    step(); chk("nop_done", 8'(state), 8'h0);

    // halt holds in ID
    opcode = 6'b111111;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", 8'(state), 8'h1);
      chk("halt_pcwre", 8'(PCWre), 8'h0);
      step();
    end
    RST = 1'b1;
    step(); chk("halt_rst_state", 8'(state), 8'h0);
    RST = 1'b0;

    // reset during sw MEM
    opcode = 6'b101011;
    step(); step(); step();
    chk("swr_mem", 8'(state), 8'h3);
    chk("swr_mem_mwr", 8'(mWR), 8'h1);
    RST = 1'b1; #1;
    chk("swr_rst_mwr", 8'(mWR), 8'h0);
    chk("swr_rst_pcwre", 8'(PCWre), 8'h0);
    step(); chk("swr_rst_state", 8'(state), 8'h0);
    RST = 1'b0; #1;
    chk("swr_after_irwre", 8'(IRWre), 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
